// File: rtl/chan_accum32_if.sv
// Handshake bundle for the channel accumulator: start/ch_num command,
// partial-sum input stream, and the result stream toward the ReLU stage.
interface chan_accum32_if #(
   parameter int DW = 32,
   parameter int CW = 8
);
   logic          start;
   logic [CW-1:0] ch_num;
   logic [DW-1:0] psum_in;
   logic          psum_valid;
   logic          psum_ready;
   logic [DW-1:0] acc_out;
   logic          acc_valid;
   logic          acc_ready;
   logic          sat;
   logic          busy;

   modport slave (
      input  start, ch_num, psum_in, psum_valid, acc_ready,
      output psum_ready, acc_out, acc_valid, sat, busy
   );

   modport master (
      output start, ch_num, psum_in, psum_valid, acc_ready,
      input  psum_ready, acc_out, acc_valid, sat, busy
   );
endinterface

// File: rtl/chan_accum32.sv
// Sums ch_num signed partial sums with saturation and holds the result
// until the downstream ReLU stage takes it.
//
// state | meaning
// IDLE  | waiting for start with a non-zero channel count
// ACCUM | accepting partial sums, one per valid beat
// HOLD  | result presented on acc_out, waiting for acc_ready
module chan_accum32 #(
   parameter int DW = 32,
   parameter int CW = 8
) (
   input logic            clk,
   input logic            rst_n,
   chan_accum32_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW-1){1'b0}}};

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] chn_q, chn_d;
   logic [DW-1:0] acc_q, acc_d;
   logic          sat_q, sat_d;

   logic [DW:0]   sum_ext;
   logic [DW-1:0] sum_sat;
   logic          ovf;
   logic          start_ok;
   logic          beat;

   // Sign-extended add; overflow when the two top bits of the wide sum disagree.
   always_comb begin
      sum_ext = {acc_q[DW-1], acc_q} + {bus.psum_in[DW-1], bus.psum_in};
      ovf     = sum_ext[DW] ^ sum_ext[DW-1];
      sum_sat = sum_ext[DW-1:0];
      if (ovf) begin
         sum_sat = sum_ext[DW] ? SAT_NEG : SAT_POS;
      end
   end

   // State and datapath registers; reset discards any partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         chn_q   <= '0;
         acc_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         chn_q   <= chn_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      chn_d    = chn_q;
      acc_d    = acc_q;
      sat_d    = sat_q;
      start_ok = bus.start && (bus.ch_num != '0);
      beat     = (state_q == ACCUM) && bus.psum_valid;

      case (state_q)
         IDLE: begin
            if (start_ok) begin
               chn_d   = bus.ch_num;
               cnt_d   = '0;
               sat_d   = 1'b0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (beat) begin
               // first beat loads so nothing from the previous result leaks in
               if (cnt_q == '0) begin
                  acc_d = bus.psum_in;
               end else begin
                  acc_d = sum_sat;
                  sat_d = sat_q | ovf;
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == chn_q - CW'(1)) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.acc_ready) begin
               if (start_ok) begin
                  chn_d   = bus.ch_num;
                  cnt_d   = '0;
                  sat_d   = 1'b0;
                  state_d = ACCUM;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded straight from registered state.
   always_comb begin
      bus.psum_ready = (state_q == ACCUM);
      bus.acc_valid  = (state_q == HOLD);
      bus.acc_out    = acc_q;
      bus.sat        = sat_q;
      bus.busy       = (state_q != IDLE);
   end

endmodule
